// File: rtl/of_eval_arbiter.sv
// Round-robin arbiter that shares one objective-function evaluator among N optimizer instances.
// Issues the selected point, waits for done or timeout, and returns fx with a one-cycle strobe.
module of_eval_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned pd      = 12,
    parameter int unsigned p       = 22,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic [N*(pd+p)-1:0]  d0_i,
    input  logic [N*(pd+p)-1:0]  d1_i,
    input  logic [N*(pd+p)-1:0]  d2_i,
    output logic [N-1:0]         grant_o,
    output logic [3+p-1:0]       fx_o,
    output logic [N-1:0]         fx_valid_o,
    output logic                 timeout_o,
    output logic                 busy_o,
    output logic                 eval_start_o,
    output logic [pd+p-1:0]      eval_d0_o,
    output logic [pd+p-1:0]      eval_d1_o,
    output logic [pd+p-1:0]      eval_d2_o,
    input  logic                 eval_done_i,
    input  logic [3+p-1:0]       eval_fx_i,
    output logic [15:0]          eval_cnt_o
);

    localparam int unsigned W  = pd + p;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RETURN = 2'd3;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [SW-1:0] ptr;
    logic [SW-1:0] sel;
    logic [SW-1:0] pick;
    logic [SW-1:0] scan;
    logic          found;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT));

    // First requesting index at or above ptr, wrapping modulo N.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        scan  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan = SW'((32'(ptr) + i) % N);
            if (!found && req_i[scan]) begin
                pick  = scan;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_i) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (eval_done_i || tmo_hit) state_d = RETURN;
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; done takes priority over a simultaneous timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            sel          <= '0;
            tmo_cnt      <= '0;
            grant_o      <= '0;
            fx_o         <= '0;
            fx_valid_o   <= '0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b0;
            eval_start_o <= 1'b0;
            eval_d0_o    <= '0;
            eval_d1_o    <= '0;
            eval_d2_o    <= '0;
            eval_cnt_o   <= '0;
        end else begin
            busy_o       <= (state_d != IDLE);
            eval_start_o <= (state_d == ISSUE);
            fx_valid_o   <= '0;
            timeout_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        sel       <= pick;
                        grant_o   <= N'(1) << pick;
                        eval_d0_o <= d0_i[pick*W +: W];
                        eval_d1_o <= d1_i[pick*W +: W];
                        eval_d2_o <= d2_i[pick*W +: W];
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT: begin
                    if (eval_done_i) begin
                        fx_o       <= eval_fx_i;
                        fx_valid_o <= N'(1) << sel;
                        eval_cnt_o <= eval_cnt_o + CW'(1);
                    end else if (tmo_hit) begin
                        fx_o       <= '1;
                        timeout_o  <= 1'b1;
                        fx_valid_o <= N'(1) << sel;
                        eval_cnt_o <= eval_cnt_o + CW'(1);
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                RETURN: begin
                    grant_o <= '0;
                    ptr     <= (32'(sel) == N - 1) ? '0 : sel + SW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_of_eval_arbiter.sv
// Self-checking bench for of_eval_arbiter: vector table of services plus reset and mid-service sequences.
module tb_of_eval_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned PD  = 12;
    localparam int unsigned P   = 22;
    localparam int unsigned TMO = 8;
    localparam int unsigned W   = PD + P;
    localparam int unsigned FW  = 3 + P;
    localparam int NV = 10;

    typedef struct {
        logic [N-1:0]  req;
        int            delay;
        logic [FW-1:0] fx;
        int            sel;
        logic          to;
    } vec_t;

    typedef struct {
        int            sel;
        logic [FW-1:0] fx;
        logic          to;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_i = '0;
    logic [N*W-1:0]    d0_i, d1_i, d2_i;
    logic [N-1:0]      grant_o;
    logic [FW-1:0]     fx_o;
    logic [N-1:0]      fx_valid_o;
    logic              timeout_o;
    logic              busy_o;
    logic              eval_start_o;
    logic [W-1:0]      eval_d0_o, eval_d1_o, eval_d2_o;
    logic              eval_done_i = 1'b0;
    logic [FW-1:0]     eval_fx_i = '0;
    logic [15:0]       eval_cnt_o;

    int   checks = 0;
    int   failures = 0;
    int   cnt_model = 0;
    exp_t sb[$];
    vec_t vecs[NV];

    of_eval_arbiter #(.N(N), .pd(PD), .p(P), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i),
        .d0_i(d0_i), .d1_i(d1_i), .d2_i(d2_i),
        .grant_o(grant_o), .fx_o(fx_o), .fx_valid_o(fx_valid_o),
        .timeout_o(timeout_o), .busy_o(busy_o), .eval_start_o(eval_start_o),
        .eval_d0_o(eval_d0_o), .eval_d1_o(eval_d1_o), .eval_d2_o(eval_d2_o),
        .eval_done_i(eval_done_i), .eval_fx_i(eval_fx_i), .eval_cnt_o(eval_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pt(input int k, input int c);
        return W'(32'h0001_0101 * (k + 1) + 32'h0010_0000 * (c + 1) + 32'h5);
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pop the oldest expected result and compare it with the strobe currently on the outputs.
    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 64'(fx_valid_o), 64'(0));
        end else begin
            e = sb.pop_front();
            chk({tag, "_fx_valid"}, 64'(fx_valid_o), 64'(onehot(e.sel)));
            chk({tag, "_fx"}, 64'(fx_o), 64'(e.fx));
            chk({tag, "_timeout"}, 64'(timeout_o), 64'(e.to));
            cnt_model++;
        end
    endtask

    task automatic check_grant(input string tag, input int s);
        chk({tag, "_grant"}, 64'(grant_o), 64'(onehot(s)));
        chk({tag, "_start"}, 64'(eval_start_o), 64'(1));
        chk({tag, "_d0"}, 64'(eval_d0_o), 64'(pt(s, 0)));
        chk({tag, "_d1"}, 64'(eval_d1_o), 64'(pt(s, 1)));
        chk({tag, "_d2"}, 64'(eval_d2_o), 64'(pt(s, 2)));
    endtask

    // One full service driven from IDLE at a negedge; returns at the negedge after RETURN.
    task automatic serve(input vec_t v, input int idx);
        int    lat;
        int    exp_lat;
        bit    seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        req_i = v.req;
        sb.push_back('{sel: v.sel, fx: (v.to ? {FW{1'b1}} : v.fx), to: v.to});
        @(negedge clk);
        check_grant(tag, v.sel);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < int'(TMO) + 6) begin
            if (v.delay >= 1 && lat == v.delay) begin
                eval_done_i = 1'b1;
                eval_fx_i = v.fx;
            end
            @(negedge clk);
            lat++;
            eval_done_i = 1'b0;
            eval_fx_i = FW'(25'h0AA_AAAA);
            if (fx_valid_o != '0) seen = 1'b1;
        end
        exp_lat = (v.delay >= 1 && v.delay <= int'(TMO) + 1) ? v.delay + 1 : int'(TMO) + 2;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (seen) check_result(tag);
        req_i[v.sel] = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, 64'({fx_valid_o, timeout_o, grant_o, busy_o}), 64'(0));
        chk({tag, "_cnt"}, 64'(eval_cnt_o), 64'(cnt_model));
    endtask

    initial begin
        vec_t v;
        logic [FW-1:0] held;
        for (int k = 0; k < int'(N); k++) begin
            d0_i[k*W +: W] = pt(k, 0);
            d1_i[k*W +: W] = pt(k, 1);
            d2_i[k*W +: W] = pt(k, 2);
        end
        vecs[0] = '{4'b1111, 3, 25'h0000111, 0, 1'b0};
        vecs[1] = '{4'b1111, 1, 25'h0000222, 1, 1'b0};
        vecs[2] = '{4'b1111, 4, 25'h0000333, 2, 1'b0};
        vecs[3] = '{4'b1111, 2, 25'h0000444, 3, 1'b0};
        vecs[4] = '{4'b1111, 6, 25'h0000555, 0, 1'b0};
        vecs[5] = '{4'b0010, 5, 25'h0123456, 1, 1'b0};
        vecs[6] = '{4'b1001, -1, 25'h0000777, 3, 1'b1};
        vecs[7] = '{4'b0110, 2, 25'h0000888, 1, 1'b0};
        vecs[8] = '{4'b0001, 9, 25'h0000999, 0, 1'b0};
        vecs[9] = '{4'b1000, 8, 25'h0000AAA, 3, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", 64'({grant_o, fx_valid_o, timeout_o, busy_o, eval_start_o}), 64'(0));
        chk("rst_fx_cnt", 64'({fx_o, eval_cnt_o}), 64'(0));
        chk("rst_d0", 64'(eval_d0_o), 64'(0));

        for (int i = 0; i < NV; i++) serve(vecs[i], i);

        // Reset two cycles into WAIT, then a stray done must be ignored.
        req_i = 4'b0100;
        @(negedge clk);
        check_grant("rstw", 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_i = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_outputs", 64'({grant_o, fx_valid_o, timeout_o, busy_o, eval_start_o}), 64'(0));
        chk("rstw_fx_cnt", 64'({fx_o, eval_cnt_o}), 64'(0));
        chk("rstw_d", 64'(eval_d0_o | eval_d1_o | eval_d2_o), 64'(0));
        cnt_model = 0;
        eval_done_i = 1'b1;
        eval_fx_i = FW'(25'h1234567);
        @(negedge clk);
        eval_done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstw_stray", 64'({fx_valid_o, busy_o, fx_o}), 64'(0));
            @(negedge clk);
        end
        v = '{4'b1111, 3, 25'h0000BBB, 0, 1'b0};
        serve(v, 10);

        // Point change and request drop while in WAIT do not disturb service.
        req_i = 4'b0100;
        held = FW'(25'h0000CCC);
        sb.push_back('{sel: 2, fx: held, to: 1'b0});
        @(negedge clk);
        check_grant("mid", 2);
        @(negedge clk);
        d0_i[2*W +: W] = ~pt(2, 0);
        req_i = '0;
        @(negedge clk);
        eval_done_i = 1'b1;
        eval_fx_i = held;
        @(negedge clk);
        eval_done_i = 1'b0;
        check_result("mid");
        chk("mid_d0_frozen", 64'(eval_d0_o), 64'(pt(2, 0)));
        @(negedge clk);
        chk("mid_cnt", 64'(eval_cnt_o), 64'(cnt_model));
        chk("mid_fx_hold", 64'(fx_o), 64'(held));
        d0_i[2*W +: W] = pt(2, 0);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
